// File: rtl/systolic_array.sv
// 4x4 weight-stationary binary (XNOR-popcount) systolic array.
// Activations flow top to bottom one row per cycle; partial sums cross each row combinationally into a register.
module systolic_array (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        load_weight_in,
    input  logic [8:0]  weight_in,
    input  logic [8:0]  activation_column_0_in,
    input  logic [8:0]  activation_column_1_in,
    input  logic [8:0]  activation_column_2_in,
    input  logic [8:0]  activation_column_3_in,
    input  logic [12:0] psum_row_0_in,
    input  logic [12:0] psum_row_1_in,
    input  logic [12:0] psum_row_2_in,
    input  logic [12:0] psum_row_3_in,
    output logic [12:0] psum_row_0_out,
    output logic [12:0] psum_row_1_out,
    output logic [12:0] psum_row_2_out,
    output logic [12:0] psum_row_3_out,
    output logic [8:0]  activation_column_0_out,
    output logic [8:0]  activation_column_1_out,
    output logic [8:0]  activation_column_2_out,
    output logic [8:0]  activation_column_3_out
);

    logic [8:0]  act_in   [4];
    logic [12:0] psum_in  [4];

    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  w_q      [4][4];
    logic [8:0]  w_d      [4][4];
    logic [8:0]  a_q      [4][4];
    logic [8:0]  a_d      [4][4];
    logic [12:0] psum_q   [4];
    logic [12:0] psum_d   [4];
    logic [3:0]  m        [4][4];

    assign act_in[0]  = activation_column_0_in;
    assign act_in[1]  = activation_column_1_in;
    assign act_in[2]  = activation_column_2_in;
    assign act_in[3]  = activation_column_3_in;
    assign psum_in[0] = psum_row_0_in;
    assign psum_in[1] = psum_row_1_in;
    assign psum_in[2] = psum_row_2_in;
    assign psum_in[3] = psum_row_3_in;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Load pointer walks row-major; any idle cycle rewinds it to PE(0,0).
    always_comb begin
        w_d   = w_q;
        cnt_d = '0;
        if (load_weight_in) begin
            w_d[cnt_q[3:2]][cnt_q[1:0]] = weight_in;
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_comb begin
        a_d = a_q;
        for (int c = 0; c < 4; c++) begin
            a_d[0][c] = act_in[c];
            for (int r = 1; r < 4; r++) begin
                a_d[r][c] = a_q[r-1][c];
            end
        end
    end

    // Contributions use the registered weight, so a same-cycle weight write lands after this edge.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            psum_d[r] = psum_in[r];
            for (int c = 0; c < 4; c++) begin
                m[r][c]   = popcount9(~(a_q[r][c] ^ w_q[r][c]));
                psum_d[r] = psum_d[r] + {9'd0, m[r][c]};
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
            for (int r = 0; r < 4; r++) begin
                psum_q[r] <= '0;
                for (int c = 0; c < 4; c++) begin
                    w_q[r][c] <= '0;
                    a_q[r][c] <= '0;
                end
            end
        end else begin
            cnt_q <= cnt_d;
            for (int r = 0; r < 4; r++) begin
                psum_q[r] <= psum_d[r];
                for (int c = 0; c < 4; c++) begin
                    w_q[r][c] <= w_d[r][c];
                    a_q[r][c] <= a_d[r][c];
                end
            end
        end
    end

    assign psum_row_0_out          = psum_q[0];
    assign psum_row_1_out          = psum_q[1];
    assign psum_row_2_out          = psum_q[2];
    assign psum_row_3_out          = psum_q[3];
    assign activation_column_0_out = a_q[3][0];
    assign activation_column_1_out = a_q[3][1];
    assign activation_column_2_out = a_q[3][2];
    assign activation_column_3_out = a_q[3][3];

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: hand-computed row sums, activation latency, reset and reload behaviour.
module tb_systolic_array;

    logic        clk_in;
    logic        rst_in;
    logic        load_weight_in;
    logic [8:0]  weight_in;
    logic [8:0]  act     [4];
    logic [12:0] psum_in [4];
    logic [12:0] psum_out[4];
    logic [8:0]  act_out [4];

    int checks;
    int errors;

    // Golden set: words in load order, and the per-column activations used with them.
    logic [8:0] gold_w [16];
    logic [8:0] gold_a [4];

    systolic_array dut (
        .clk_in                  (clk_in),
        .rst_in                  (rst_in),
        .load_weight_in          (load_weight_in),
        .weight_in               (weight_in),
        .activation_column_0_in  (act[0]),
        .activation_column_1_in  (act[1]),
        .activation_column_2_in  (act[2]),
        .activation_column_3_in  (act[3]),
        .psum_row_0_in           (psum_in[0]),
        .psum_row_1_in           (psum_in[1]),
        .psum_row_2_in           (psum_in[2]),
        .psum_row_3_in           (psum_in[3]),
        .psum_row_0_out          (psum_out[0]),
        .psum_row_1_out          (psum_out[1]),
        .psum_row_2_out          (psum_out[2]),
        .psum_row_3_out          (psum_out[3]),
        .activation_column_0_out (act_out[0]),
        .activation_column_1_out (act_out[1]),
        .activation_column_2_out (act_out[2]),
        .activation_column_3_out (act_out[3])
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic check_rows(input string tag, input logic [12:0] e0, input logic [12:0] e1,
                              input logic [12:0] e2, input logic [12:0] e3);
        check($sformatf("%s_row0", tag), psum_out[0], e0);
        check($sformatf("%s_row1", tag), psum_out[1], e1);
        check($sformatf("%s_row2", tag), psum_out[2], e2);
        check($sformatf("%s_row3", tag), psum_out[3], e3);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_psum%0d", tag, i), psum_out[i], 13'd0);
            check($sformatf("%s_act%0d", tag, i), {4'd0, act_out[i]}, 13'd0);
        end
    endtask

    task automatic load_word(input logic [8:0] v);
        load_weight_in = 1'b1;
        weight_in      = v;
        tick();
    endtask

    task automatic set_psum(input logic [12:0] p0, input logic [12:0] p1,
                            input logic [12:0] p2, input logic [12:0] p3);
        psum_in[0] = p0;
        psum_in[1] = p1;
        psum_in[2] = p2;
        psum_in[3] = p3;
    endtask

    // Column c is applied from cycle c and held; four more cycles let column 3 reach row 3.
    task automatic apply_skewed(input logic [8:0] a0, input logic [8:0] a1,
                                input logic [8:0] a2, input logic [8:0] a3);
        act[0] = a0; tick();
        act[1] = a1; tick();
        act[2] = a2; tick();
        act[3] = a3; tick();
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;

        gold_a[0] = 9'h000; gold_a[1] = 9'h1FF; gold_a[2] = 9'h00F; gold_a[3] = 9'h1F0;
        // row sums with psum_in=0: 9+0+9+0=18, 8+8+1+9=26, 0+9+5+5=19, 7+8+8+8=31
        gold_w[0]  = 9'h000; gold_w[1]  = 9'h000; gold_w[2]  = 9'h00F; gold_w[3]  = 9'h00F;
        gold_w[4]  = 9'h001; gold_w[5]  = 9'h0FF; gold_w[6]  = 9'h0F0; gold_w[7]  = 9'h1F0;
        gold_w[8]  = 9'h1FF; gold_w[9]  = 9'h1FF; gold_w[10] = 9'h000; gold_w[11] = 9'h100;
        gold_w[12] = 9'h003; gold_w[13] = 9'h1FE; gold_w[14] = 9'h01F; gold_w[15] = 9'h1F1;

        rst_in         = 1'b0;
        load_weight_in = 1'b0;
        weight_in      = '0;
        for (int i = 0; i < 4; i++) act[i] = '0;
        set_psum(13'd0, 13'd5, 13'd10, 13'd20);

        // Reset state, without any clock edge
        #2;
        check_all_zero("reset");

        // First cycle after reset: W=0, A=0 -> each PE contributes 9
        rst_in = 1'b1;
        tick();
        check_rows("post_reset", 13'd36, 13'd41, 13'd46, 13'd56);
        set_psum(13'd0, 13'd0, 13'd0, 13'd0);

        // All-ones weights and activations
        for (int i = 0; i < 16; i++) load_word(9'h1FF);
        load_weight_in = 1'b0;
        apply_skewed(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
        for (int i = 0; i < 4; i++) check($sformatf("ones_actout%0d", i), {4'd0, act_out[i]}, 13'h1FF);
        tick();
        check_rows("ones", 13'd36, 13'd36, 13'd36, 13'd36);

        // Wraparound modulo 2^13
        psum_in[0] = 13'h1FF0;
        tick();
        check("wrap_row0", psum_out[0], 13'h0014);
        psum_in[0] = 13'd0;

        // Zero activations against ones weights: psum passes through
        for (int i = 0; i < 4; i++) act[i] = 9'h000;
        for (int i = 0; i < 4; i++) tick();
        set_psum(13'd100, 13'd200, 13'd300, 13'd400);
        tick();
        check_rows("passthru", 13'd100, 13'd200, 13'd300, 13'd400);
        set_psum(13'd0, 13'd0, 13'd0, 13'd0);

        // Alternating weights: even columns match, odd columns contribute 0
        for (int i = 0; i < 16; i++) load_word((i % 2 == 0) ? 9'h1FF : 9'h000);
        load_weight_in = 1'b0;
        apply_skewed(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
        tick();
        check_rows("alt", 13'd18, 13'd18, 13'd18, 13'd18);

        // Single-cycle pulse on column 2 appears 4 edges later, one cycle wide
        for (int i = 0; i < 4; i++) act[i] = 9'h000;
        for (int i = 0; i < 4; i++) tick();
        act[2] = 9'h0A5;
        tick();
        act[2] = 9'h000;
        check("pulse_e1", {4'd0, act_out[2]}, 13'd0);
        tick();
        check("pulse_e2", {4'd0, act_out[2]}, 13'd0);
        tick();
        check("pulse_e3", {4'd0, act_out[2]}, 13'd0);
        tick();
        check("pulse_e4", {4'd0, act_out[2]}, 13'h0A5);
        tick();
        check("pulse_e5", {4'd0, act_out[2]}, 13'd0);

        // Partial load, idle cycle, then full golden load must restart at PE(0,0)
        for (int i = 0; i < 3; i++) load_word(9'h1FF);
        load_weight_in = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) load_word(gold_w[i]);
        load_weight_in = 1'b0;
        apply_skewed(gold_a[0], gold_a[1], gold_a[2], gold_a[3]);
        tick();
        check_rows("golden", 13'd18, 13'd26, 13'd19, 13'd31);

        // Weight write in the same cycle as flow: the old W is used at that edge
        load_weight_in = 1'b1;
        weight_in      = 9'h1FF;
        tick();
        check("wr_same_edge_row0", psum_out[0], 13'd18);
        load_weight_in = 1'b0;
        tick();
        check("wr_next_edge_row0", psum_out[0], 13'd9);
        check("wr_next_edge_row1", psum_out[1], 13'd26);

        // Reset mid-load clears everything immediately, then a fresh load works
        for (int i = 0; i < 7; i++) load_word(9'h1FF);
        rst_in = 1'b0;
        #1;
        check_all_zero("midload_reset");
        rst_in = 1'b1;
        for (int i = 0; i < 16; i++) load_word(gold_w[i]);
        load_weight_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        tick();
        check_rows("reload", 13'd18, 13'd26, 13'd19, 13'd31);
        for (int i = 0; i < 4; i++) check($sformatf("reload_actout%0d", i), {4'd0, act_out[i]}, {4'd0, gold_a[i]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
